addr_pair_reg: RTL and testbench
================================

// Module: addr_pair_reg
// PURPOSE
//  Parametrised successor to the PC/D/T address register pairs on the memory_bus_h/l side.
//  Holds a {high,low} address.
//  Adds these in-register operations:
//   - full-width increment with carry;
//   - signed branch offset;
//   - unsigned index add.
//  Page crossing is detected and resolved by a 2-state fix-up FSM that costs one extra cycle.
//  This matches 6502 branch/indexed timing and exposes busy/page_cross to control.
// PARAMETERS
//  HALF_W     8       width of each half (low and high); full address is 2*HALF_W
//  RST_VAL    16'h0   reset value of {out_h,out_l}, 2*HALF_W bits
//  WRAP_PAGE  0       1: offset/index adds never touch high half (zero-page wrap mode), no fix-up
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  ld_l       in   1         load low half from l_in
//  ld_h       in   1         load high half from h_in
//  l_in       in   HALF_W    low load data (from PCLmux-style mux)
//  h_in       in   HALF_W    high load data
//  inc        in   1         increment full address by 1
//  offs_en    in   1         add sign-extended offs to address
//  offs       in   HALF_W    two's-complement branch offset
//  idx_en     in   1         add zero-extended idx to address
//  idx        in   HALF_W    unsigned index (X/Y)
//  out_l      out  HALF_W    low half, drives tristates to data/memory bus
//  out_h      out  HALF_W    high half
//  busy       out  1         fix-up cycle pending; new ops ignored except loads
//  page_cross out  1         last offset/index op crossed a page (held until next op)
//  done       out  1         one-cycle pulse, final address valid this cycle
// BEHAVIOUR
//  - Reset (rst_n=0, async): {out_h,out_l}=RST_VAL; state=IDLE; busy=0; page_cross=0; done=0.
//  - States:
//     IDLE
//     FIXH: carry/borrow pending, direction held in register fix_dir (+1/-1).
//  - Priority each cycle: ld_l/ld_h > offs_en > idx_en > inc.
//  - ld_l and ld_h are independent and may be combined in one cycle.
//  - Loads:
//     - take effect at the next edge in either state;
//     - done=1 next cycle;
//     - a load of high in FIXH cancels the fix-up (state->IDLE);
//     - a load of low only in FIXH leaves the fix-up pending.
//  - inc (IDLE only):
//     - full 2*HALF_W increment in one cycle, wraps at all-ones to 0;
//     - done=1 next cycle; page_cross unchanged.
//  - offs_en (IDLE):
//     - sum = out_l + offs, mod 2^HALF_W, written to low;
//     - positive offs with carry-out, or negative offs without carry-out, means crossing.
//  - idx_en (IDLE):
//     - low = out_l + idx mod 2^HALF_W;
//     - carry-out means crossing (+1 only).
//  - No crossing, or WRAP_PAGE=1:
//     - single cycle; page_cross<=0 (WRAP_PAGE=1: always 0); done=1 next cycle.
//  - Crossing with WRAP_PAGE=0:
//     - cycle 1 edge: low updated, page_cross<=1, busy<=1, state->FIXH;
//     - cycle 2 edge: out_h<=out_h+fix_dir mod 2^HALF_W, busy<=0, state->IDLE, done=1.
//  - busy is registered: high exactly for the single FIXH cycle.
//  - inc/offs_en/idx_en asserted while busy are dropped and not queued.
//  - Simultaneous offs_en and idx_en: offs_en wins, idx ignored.
//  - High wrap: FIXH +1 from high=all-ones gives 0; -1 from 0 gives all-ones.
//  - done is 0 in every cycle not listed above.
// TESTING (HALF_W=8, RST_VAL=16'h0000 unless stated)
//  1. Reset: pulse rst_n=0 mid-cycle -> out=0x0000 immediately; busy=0, page_cross=0.
//  2. ld_l=1,l_in=0x34,ld_h=1,h_in=0x12 -> 0x1234, done; inc at 0x12FF -> 0x1300; inc at 0xFFFF -> 0x0000.
//  3. At 0x12F8, offs=0x10:
//      cycle+1 out=0x1208, busy=1, page_cross=1;
//      cycle+2 out=0x1308, busy=0, done=1.
//  4. At 0x1205, offs=0xF0 (-16) -> 0x12F5 busy=1, then 0x11F5.
//     Same start, offs=0x02 -> 0x1207 in 1 cycle, page_cross=0.
//  5. WRAP_PAGE=1, at 0x12FE, idx_en with idx=0x05 -> 0x1203, busy never 1, page_cross=0.
//     inc asserted during FIXH (WRAP_PAGE=0) -> ignored, result unchanged.
//  6. Mid-operation:
//      - rst_n=0 during FIXH -> 0x0000, IDLE, no done;
//      - ld_h=1,h_in=0x40 during FIXH -> high=0x40, fix-up cancelled.

Source files
------------

// File: rtl/addr_pair_reg_if.sv
// Handshake/bus bundle between the address-pair register and its controller.
// Carries load, arithmetic-op and status signals; no timing of its own.
// No backpressure: the controller watches busy and re-issues dropped ops itself.
interface addr_pair_reg_if #(
    parameter int HALF_W = 8
);
    logic              ld_l;
    logic              ld_h;
    logic [HALF_W-1:0] l_in;
    logic [HALF_W-1:0] h_in;
    logic              inc;
    logic              offs_en;
    logic [HALF_W-1:0] offs;
    logic              idx_en;
    logic [HALF_W-1:0] idx;
    logic [HALF_W-1:0] out_l;
    logic [HALF_W-1:0] out_h;
    logic              busy;
    logic              page_cross;
    logic              done;

    // Controller side: issues loads and ops, observes the address and status.
    modport master (
        output ld_l, ld_h, l_in, h_in, inc, offs_en, offs, idx_en, idx,
        input  out_l, out_h, busy, page_cross, done
    );

    // Register side.
    modport slave (
        input  ld_l, ld_h, l_in, h_in, inc, offs_en, offs, idx_en, idx,
        output out_l, out_h, busy, page_cross, done
    );
endinterface

// File: rtl/addr_pair_reg.sv
// {high,low} address register pair with increment, signed offset and index add.
// Latency: 1 cycle per op, 2 cycles when an offset/index add crosses a page.
// Backpressure: busy for the fix-up cycle; inc/offs/idx then dropped, loads honoured.
module addr_pair_reg #(
    parameter int                  HALF_W    = 8,
    parameter logic [2*HALF_W-1:0] RST_VAL   = '0,
    parameter bit                  WRAP_PAGE = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    addr_pair_reg_if.slave bus
);
    localparam logic [HALF_W-1:0]   ONE_H = {{(HALF_W-1){1'b0}}, 1'b1};
    localparam logic [2*HALF_W-1:0] ONE_F = {{(2*HALF_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        FIXH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [HALF_W-1:0] low_q, low_d;
    logic [HALF_W-1:0] high_q, high_d;
    logic              fix_dir_q, fix_dir_d;   // 0: high +1, 1: high -1
    logic              busy_q, busy_d;
    logic              page_cross_q, page_cross_d;
    logic              done_q, done_d;

    logic [HALF_W:0]     offs_sum;
    logic [HALF_W:0]     idx_sum;
    logic [2*HALF_W-1:0] inc_sum;
    logic                offs_cross;
    logic                idx_cross;
    logic                offs_neg;

    // Adders and page-crossing detection on the low half.
    // A negative offset crosses when there is no carry out (borrow into high).
    always_comb begin
        offs_sum   = {1'b0, low_q} + {1'b0, bus.offs};
        idx_sum    = {1'b0, low_q} + {1'b0, bus.idx};
        inc_sum    = {high_q, low_q} + ONE_F;
        offs_neg   = bus.offs[HALF_W-1];
        offs_cross = offs_neg ? ~offs_sum[HALF_W] : offs_sum[HALF_W];
        idx_cross  = idx_sum[HALF_W];
    end

    // Next-state: loads win, then offset, then index, then increment.
    // In FIXH only loads are honoured; a high load replaces the fix-up result.
    always_comb begin
        state_d      = state_q;
        low_d        = low_q;
        high_d       = high_q;
        fix_dir_d    = fix_dir_q;
        busy_d       = 1'b0;
        page_cross_d = page_cross_q;
        done_d       = 1'b0;

        if (state_q == FIXH) begin
            state_d = IDLE;
            done_d  = 1'b1;
            high_d  = fix_dir_q ? (high_q - ONE_H) : (high_q + ONE_H);
            if (bus.ld_l) low_d  = bus.l_in;
            if (bus.ld_h) high_d = bus.h_in;
        end else if (bus.ld_l || bus.ld_h) begin
            done_d = 1'b1;
            if (bus.ld_l) low_d  = bus.l_in;
            if (bus.ld_h) high_d = bus.h_in;
        end else if (bus.offs_en) begin
            low_d = offs_sum[HALF_W-1:0];
            if (offs_cross && !WRAP_PAGE) begin
                state_d      = FIXH;
                busy_d       = 1'b1;
                page_cross_d = 1'b1;
                fix_dir_d    = offs_neg;
            end else begin
                page_cross_d = 1'b0;
                done_d       = 1'b1;
            end
        end else if (bus.idx_en) begin
            low_d = idx_sum[HALF_W-1:0];
            if (idx_cross && !WRAP_PAGE) begin
                state_d      = FIXH;
                busy_d       = 1'b1;
                page_cross_d = 1'b1;
                fix_dir_d    = 1'b0;
            end else begin
                page_cross_d = 1'b0;
                done_d       = 1'b1;
            end
        end else if (bus.inc) begin
            {high_d, low_d} = inc_sum;
            done_d          = 1'b1;
        end
    end

    // State, address and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            low_q        <= RST_VAL[HALF_W-1:0];
            high_q       <= RST_VAL[2*HALF_W-1:HALF_W];
            fix_dir_q    <= 1'b0;
            busy_q       <= 1'b0;
            page_cross_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            low_q        <= low_d;
            high_q       <= high_d;
            fix_dir_q    <= fix_dir_d;
            busy_q       <= busy_d;
            page_cross_q <= page_cross_d;
            done_q       <= done_d;
        end
    end

    assign bus.out_l      = low_q;
    assign bus.out_h      = high_q;
    assign bus.busy       = busy_q;
    assign bus.page_cross = page_cross_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_addr_pair_reg.sv
// Bench for addr_pair_reg: page-fixup instance and zero-page-wrap instance side by side.
// Both share one stimulus stream and are compared each cycle against an address-level model.
// Directed steps first, then a randomized run.
module tb_addr_pair_reg;
    logic       clk;
    logic       rst_n;
    logic       ld_l, ld_h, inc, offs_en, idx_en;
    logic [7:0] l_in, h_in, offs, idx;

    int checks;
    int failures;

    // Reference model state, index 0 = WRAP_PAGE 0, index 1 = WRAP_PAGE 1.
    logic [15:0] m_addr [2];
    logic [7:0]  m_fixh [2];
    logic        m_busy [2];
    logic        m_pc   [2];
    logic        m_done [2];

    addr_pair_reg_if #(.HALF_W(8)) bus0 ();
    addr_pair_reg_if #(.HALF_W(8)) bus1 ();

    assign bus0.ld_l = ld_l;       assign bus1.ld_l = ld_l;
    assign bus0.ld_h = ld_h;       assign bus1.ld_h = ld_h;
    assign bus0.l_in = l_in;       assign bus1.l_in = l_in;
    assign bus0.h_in = h_in;       assign bus1.h_in = h_in;
    assign bus0.inc = inc;         assign bus1.inc = inc;
    assign bus0.offs_en = offs_en; assign bus1.offs_en = offs_en;
    assign bus0.offs = offs;       assign bus1.offs = offs;
    assign bus0.idx_en = idx_en;   assign bus1.idx_en = idx_en;
    assign bus0.idx = idx;         assign bus1.idx = idx;

    addr_pair_reg #(.HALF_W(8), .RST_VAL(16'h0000), .WRAP_PAGE(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    addr_pair_reg #(.HALF_W(8), .RST_VAL(16'h0000), .WRAP_PAGE(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_addr[k] = 16'h0000;
            m_fixh[k] = 8'h00;
            m_busy[k] = 1'b0;
            m_pc[k]   = 1'b0;
            m_done[k] = 1'b0;
        end
    endtask

    // One clock of the model, working on whole 16-bit addresses:
    // a page is crossed when the full-width target has a different high byte.
    task automatic model_step(input int k);
        logic [15:0] a;
        logic [15:0] t;
        a = m_addr[k];
        m_done[k] = 1'b0;
        if (m_busy[k]) begin
            a[15:8] = m_fixh[k];
            if (ld_l) a[7:0]  = l_in;
            if (ld_h) a[15:8] = h_in;
            m_busy[k] = 1'b0;
            m_done[k] = 1'b1;
        end else if (ld_l || ld_h) begin
            if (ld_l) a[7:0]  = l_in;
            if (ld_h) a[15:8] = h_in;
            m_done[k] = 1'b1;
        end else if (offs_en || idx_en) begin
            if (offs_en) t = a + {{8{offs[7]}}, offs};
            else         t = a + {8'h00, idx};
            a[7:0] = t[7:0];
            if (t[15:8] != m_addr[k][15:8] && k == 0) begin
                m_busy[k] = 1'b1;
                m_pc[k]   = 1'b1;
                m_fixh[k] = t[15:8];
            end else begin
                m_pc[k]   = 1'b0;
                m_done[k] = 1'b1;
            end
        end else if (inc) begin
            a = a + 16'd1;
            m_done[k] = 1'b1;
        end
        m_addr[k] = a;
    endtask

    task automatic cmp_all(input string step);
        chk($sformatf("%s out0", step),  {bus0.out_h, bus0.out_l}, m_addr[0]);
        chk($sformatf("%s busy0", step), {15'd0, bus0.busy},       {15'd0, m_busy[0]});
        chk($sformatf("%s pc0", step),   {15'd0, bus0.page_cross}, {15'd0, m_pc[0]});
        chk($sformatf("%s done0", step), {15'd0, bus0.done},       {15'd0, m_done[0]});
        chk($sformatf("%s out1", step),  {bus1.out_h, bus1.out_l}, m_addr[1]);
        chk($sformatf("%s busy1", step), {15'd0, bus1.busy},       {15'd0, m_busy[1]});
        chk($sformatf("%s pc1", step),   {15'd0, bus1.page_cross}, {15'd0, m_pc[1]});
        chk($sformatf("%s done1", step), {15'd0, bus1.done},       {15'd0, m_done[1]});
    endtask

    task automatic clr_in();
        ld_l = 0; ld_h = 0; inc = 0; offs_en = 0; idx_en = 0;
        l_in = 0; h_in = 0; offs = 0; idx = 0;
    endtask

    // Called shortly after a rising edge with inputs set; advances one clock and checks.
    task automatic cyc(input string step);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        cmp_all(step);
        clr_in();
    endtask

    task automatic load(input logic [15:0] v);
        ld_l = 1; ld_h = 1; l_in = v[7:0]; h_in = v[15:8];
        cyc("load");
    endtask

    // Reset pulse in the middle of a cycle; outputs must clear without a clock.
    task automatic async_reset(input string step);
        #2 rst_n = 1'b0;
        model_reset();
        #1 cmp_all(step);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clr_in();
        model_reset();
        rst_n = 1'b0;
        #12;
        cmp_all("reset");
        rst_n = 1'b1;

        // Loads and increment carry/wrap.
        load(16'h1234);
        chk("ld_both", {bus0.out_h, bus0.out_l}, 16'h1234);
        chk("ld_done", {15'd0, bus0.done}, 16'd1);
        async_reset("rst_mid");
        chk("rst_mid_lit", {bus0.out_h, bus0.out_l}, 16'h0000);
        load(16'h12FF);
        inc = 1; cyc("inc_carry");
        chk("inc_12ff", {bus0.out_h, bus0.out_l}, 16'h1300);
        load(16'hFFFF);
        inc = 1; cyc("inc_wrap");
        chk("inc_ffff", {bus0.out_h, bus0.out_l}, 16'h0000);

        // Positive offset crossing a page.
        load(16'h12F8);
        offs_en = 1; offs = 8'h10; cyc("offs_pos1");
        chk("offs_pos1_lit", {bus0.out_h, bus0.out_l}, 16'h1208);
        chk("offs_pos1_busy", {15'd0, bus0.busy}, 16'd1);
        cyc("offs_pos2");
        chk("offs_pos2_lit", {bus0.out_h, bus0.out_l}, 16'h1308);
        chk("offs_pos2_done", {15'd0, bus0.done}, 16'd1);

        // Negative offset borrow, and a short non-crossing branch.
        load(16'h1205);
        offs_en = 1; offs = 8'hF0; cyc("offs_neg1");
        chk("offs_neg1_lit", {bus0.out_h, bus0.out_l}, 16'h12F5);
        cyc("offs_neg2");
        chk("offs_neg2_lit", {bus0.out_h, bus0.out_l}, 16'h11F5);
        load(16'h1205);
        offs_en = 1; offs = 8'h02; cyc("offs_short");
        chk("offs_short_lit", {bus0.out_h, bus0.out_l}, 16'h1207);
        chk("offs_short_pc", {15'd0, bus0.page_cross}, 16'd0);

        // Index carry: wrap instance stays in page; inc during fix-up is dropped.
        load(16'h12FE);
        idx_en = 1; idx = 8'h05; cyc("idx_cross");
        chk("idx_wrap_lit", {bus1.out_h, bus1.out_l}, 16'h1203);
        chk("idx_wrap_busy", {15'd0, bus1.busy}, 16'd0);
        inc = 1; cyc("inc_in_fixh");
        chk("inc_in_fixh_lit", {bus0.out_h, bus0.out_l}, 16'h1303);

        // Reset during fix-up: no done afterwards.
        load(16'h12F8);
        offs_en = 1; offs = 8'h10; cyc("pre_rst");
        async_reset("rst_fixh");
        cyc("post_rst");
        chk("post_rst_done", {15'd0, bus0.done}, 16'd0);

        // High load during fix-up cancels it; low-only load keeps it.
        load(16'h12F8);
        offs_en = 1; offs = 8'h10; cyc("pre_ldh");
        ld_h = 1; h_in = 8'h40; cyc("ldh_fixh");
        chk("ldh_fixh_lit", {bus0.out_h, bus0.out_l}, 16'h4008);
        cyc("ldh_idle");
        load(16'h12F8);
        offs_en = 1; offs = 8'h10; cyc("pre_ldl");
        ld_l = 1; l_in = 8'h55; cyc("ldl_fixh");
        chk("ldl_fixh_lit", {bus0.out_h, bus0.out_l}, 16'h1355);

        // offs beats idx; high wraps in both directions.
        load(16'h1210);
        offs_en = 1; offs = 8'h02; idx_en = 1; idx = 8'hF0; cyc("offs_wins");
        chk("offs_wins_lit", {bus0.out_h, bus0.out_l}, 16'h1212);
        load(16'h0005);
        offs_en = 1; offs = 8'hF0; cyc("hwrap_dn1");
        cyc("hwrap_dn2");
        chk("hwrap_dn_lit", {bus0.out_h, bus0.out_l}, 16'hFFF5);
        load(16'hFFF8);
        idx_en = 1; idx = 8'h10; cyc("hwrap_up1");
        cyc("hwrap_up2");
        chk("hwrap_up_lit", {bus0.out_h, bus0.out_l}, 16'h0008);

        // Randomized mix of all operations.
        for (int n = 0; n < 400; n++) begin
            ld_l    = ($urandom_range(0, 11) == 0);
            ld_h    = ($urandom_range(0, 11) == 0);
            l_in    = 8'($urandom);
            h_in    = 8'($urandom);
            offs_en = ($urandom_range(0, 2) == 0);
            offs    = 8'($urandom);
            idx_en  = ($urandom_range(0, 2) == 0);
            idx     = 8'($urandom);
            inc     = ($urandom_range(0, 1) == 0);
            cyc("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
